// File: rtl/spi_frame_assembler.sv
// Turns the synchronised SPI byte stream (header, 16-bit start address, payload) into
// full-width activation / parameter / instruction memory writes with an auto-incrementing address.
module spi_frame_assembler #(
  parameter int                        WIDTH_SPI_WORD   = 8,
  parameter int                        WIDTH_ADDR_ACT   = 12,
  parameter int                        WIDTH_ACT_MEM    = 8,
  parameter logic [WIDTH_SPI_WORD-1:0] ACT_MEM_HEADER   = 8'b10,
  parameter int                        WIDTH_ADDR_PARAM = 13,
  parameter int                        WIDTH_PARAM_MEM  = 128,
  parameter logic [WIDTH_SPI_WORD-1:0] PARAM_MEM_HEADER = 8'b01,
  parameter int                        WIDTH_ADDR_INST  = 6,
  parameter int                        WIDTH_INST_MEM   = 80,
  parameter logic [WIDTH_SPI_WORD-1:0] INST_MEM_HEADER  = 8'b11
) (
  input  logic                        clk,
  input  logic                        reset_n,
  input  logic                        byte_valid,
  input  logic [WIDTH_SPI_WORD-1:0]   byte_data,
  input  logic                        frame_end,
  output logic [WIDTH_ADDR_ACT-1:0]   act_mem_addr,
  output logic [WIDTH_ACT_MEM-1:0]    act_mem_data,
  output logic                        act_mem_wren,
  output logic [WIDTH_ADDR_PARAM-1:0] param_mem_addr,
  output logic [WIDTH_PARAM_MEM-1:0]  param_mem_data,
  output logic                        param_mem_wren,
  output logic [WIDTH_ADDR_INST-1:0]  inst_mem_addr,
  output logic [WIDTH_INST_MEM-1:0]   inst_mem_data,
  output logic                        inst_mem_wren,
  output logic                        busy,
  output logic                        frame_error
);

  localparam int ADDR_W   = 2 * WIDTH_SPI_WORD;
  localparam int PACK_W0  = (WIDTH_PARAM_MEM > WIDTH_INST_MEM) ? WIDTH_PARAM_MEM : WIDTH_INST_MEM;
  localparam int PACK_W   = (PACK_W0 > WIDTH_ACT_MEM) ? PACK_W0 : WIDTH_ACT_MEM;
  localparam int ACT_NB   = WIDTH_ACT_MEM / WIDTH_SPI_WORD;
  localparam int PARAM_NB = WIDTH_PARAM_MEM / WIDTH_SPI_WORD;
  localparam int INST_NB  = WIDTH_INST_MEM / WIDTH_SPI_WORD;
  localparam int CNT_W    = $clog2(PACK_W / WIDTH_SPI_WORD + 1);

  typedef enum logic [2:0] {S_IDLE, S_ADDR_HI, S_ADDR_LO, S_DATA, S_DISCARD} state_e;
  typedef enum logic [1:0] {SEL_ACT, SEL_PARAM, SEL_INST} sel_e;

  state_e                      state_q, state_d;
  sel_e                        sel_q, sel_d;
  logic [WIDTH_SPI_WORD-1:0]   hi_q, hi_d;
  logic [ADDR_W-1:0]           addr_q, addr_d;
  logic [CNT_W-1:0]            cnt_q, cnt_d;
  logic [CNT_W-1:0]            nb, lane;
  logic [PACK_W-1:0]           pack_q, pack_d;
  logic                        busy_q, busy_d, err_q, err_d;
  logic [WIDTH_ADDR_ACT-1:0]   act_addr_q, act_addr_d;
  logic [WIDTH_ACT_MEM-1:0]    act_data_q, act_data_d;
  logic                        act_wren_q, act_wren_d;
  logic [WIDTH_ADDR_PARAM-1:0] param_addr_q, param_addr_d;
  logic [WIDTH_PARAM_MEM-1:0]  param_data_q, param_data_d;
  logic                        param_wren_q, param_wren_d;
  logic [WIDTH_ADDR_INST-1:0]  inst_addr_q, inst_addr_d;
  logic [WIDTH_INST_MEM-1:0]   inst_data_q, inst_data_d;
  logic                        inst_wren_q, inst_wren_d;

  always_comb begin
    nb = CNT_W'(ACT_NB);
    case (sel_q)
      SEL_PARAM: nb = CNT_W'(PARAM_NB);
      SEL_INST:  nb = CNT_W'(INST_NB);
      default:   nb = CNT_W'(ACT_NB);
    endcase
  end

  // Byte k of a word lands in lane nb-1-k, so the first payload byte is the word's top byte.
  assign lane = nb - cnt_q - CNT_W'(1);

  always_comb begin
    state_d      = state_q;
    sel_d        = sel_q;
    hi_d         = hi_q;
    addr_d       = addr_q;
    cnt_d        = cnt_q;
    pack_d       = pack_q;
    busy_d       = busy_q;
    err_d        = err_q;
    act_addr_d   = act_addr_q;
    act_data_d   = act_data_q;
    act_wren_d   = 1'b0;
    param_addr_d = param_addr_q;
    param_data_d = param_data_q;
    param_wren_d = 1'b0;
    inst_addr_d  = inst_addr_q;
    inst_data_d  = inst_data_q;
    inst_wren_d  = 1'b0;

    if (byte_valid) begin
      case (state_q)
        S_IDLE: begin
          busy_d  = 1'b1;
          err_d   = 1'b0;
          state_d = S_ADDR_HI;
          if (byte_data == ACT_MEM_HEADER)         sel_d = SEL_ACT;
          else if (byte_data == PARAM_MEM_HEADER)  sel_d = SEL_PARAM;
          else if (byte_data == INST_MEM_HEADER)   sel_d = SEL_INST;
          else begin
            err_d   = 1'b1;
            state_d = S_DISCARD;
          end
        end
        S_ADDR_HI: begin
          hi_d    = byte_data;
          state_d = S_ADDR_LO;
        end
        S_ADDR_LO: begin
          addr_d  = {hi_q, byte_data};
          cnt_d   = '0;
          state_d = S_DATA;
        end
        S_DATA: begin
          pack_d[int'(lane)*WIDTH_SPI_WORD +: WIDTH_SPI_WORD] = byte_data;
          if (cnt_q == nb - CNT_W'(1)) begin
            cnt_d  = '0;
            addr_d = addr_q + ADDR_W'(1);
            case (sel_q)
              SEL_PARAM: begin
                param_addr_d = addr_q[WIDTH_ADDR_PARAM-1:0];
                param_data_d = pack_d[WIDTH_PARAM_MEM-1:0];
                param_wren_d = 1'b1;
              end
              SEL_INST: begin
                inst_addr_d = addr_q[WIDTH_ADDR_INST-1:0];
                inst_data_d = pack_d[WIDTH_INST_MEM-1:0];
                inst_wren_d = 1'b1;
              end
              default: begin
                act_addr_d = addr_q[WIDTH_ADDR_ACT-1:0];
                act_data_d = pack_d[WIDTH_ACT_MEM-1:0];
                act_wren_d = 1'b1;
              end
            endcase
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end

    // frame_end is judged after any same-cycle byte, so a completing byte still writes.
    if (frame_end) begin
      if ((state_d == S_DATA && cnt_d != '0) || state_d == S_ADDR_HI || state_d == S_ADDR_LO)
        err_d = 1'b1;
      state_d = S_IDLE;
      busy_d  = 1'b0;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= S_IDLE;
      sel_q        <= SEL_ACT;
      hi_q         <= '0;
      addr_q       <= '0;
      cnt_q        <= '0;
      pack_q       <= '0;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
      act_addr_q   <= '0;
      act_data_q   <= '0;
      act_wren_q   <= 1'b0;
      param_addr_q <= '0;
      param_data_q <= '0;
      param_wren_q <= 1'b0;
      inst_addr_q  <= '0;
      inst_data_q  <= '0;
      inst_wren_q  <= 1'b0;
    end else begin
      state_q      <= state_d;
      sel_q        <= sel_d;
      hi_q         <= hi_d;
      addr_q       <= addr_d;
      cnt_q        <= cnt_d;
      pack_q       <= pack_d;
      busy_q       <= busy_d;
      err_q        <= err_d;
      act_addr_q   <= act_addr_d;
      act_data_q   <= act_data_d;
      act_wren_q   <= act_wren_d;
      param_addr_q <= param_addr_d;
      param_data_q <= param_data_d;
      param_wren_q <= param_wren_d;
      inst_addr_q  <= inst_addr_d;
      inst_data_q  <= inst_data_d;
      inst_wren_q  <= inst_wren_d;
    end
  end

  assign act_mem_addr   = act_addr_q;
  assign act_mem_data   = act_data_q;
  assign act_mem_wren   = act_wren_q;
  assign param_mem_addr = param_addr_q;
  assign param_mem_data = param_data_q;
  assign param_mem_wren = param_wren_q;
  assign inst_mem_addr  = inst_addr_q;
  assign inst_mem_data  = inst_data_q;
  assign inst_mem_wren  = inst_wren_q;
  assign busy           = busy_q;
  assign frame_error    = err_q;

endmodule

// File: tb/tb_spi_frame_assembler.sv
// Bench for spi_frame_assembler: directed and random frames compared against a frame-level
// model that lists the memory writes each frame should produce.
module tb_spi_frame_assembler;

  logic          clk = 1'b0;
  logic          reset_n = 1'b0;
  logic          byte_valid = 1'b0;
  logic [7:0]    byte_data = '0;
  logic          frame_end = 1'b0;
  logic [11:0]   act_mem_addr;
  logic [7:0]    act_mem_data;
  logic          act_mem_wren;
  logic [12:0]   param_mem_addr;
  logic [127:0]  param_mem_data;
  logic          param_mem_wren;
  logic [5:0]    inst_mem_addr;
  logic [79:0]   inst_mem_data;
  logic          inst_mem_wren;
  logic          busy;
  logic          frame_error;

  spi_frame_assembler dut (
    .clk(clk), .reset_n(reset_n), .byte_valid(byte_valid), .byte_data(byte_data),
    .frame_end(frame_end),
    .act_mem_addr(act_mem_addr), .act_mem_data(act_mem_data), .act_mem_wren(act_mem_wren),
    .param_mem_addr(param_mem_addr), .param_mem_data(param_mem_data),
    .param_mem_wren(param_mem_wren),
    .inst_mem_addr(inst_mem_addr), .inst_mem_data(inst_mem_data), .inst_mem_wren(inst_mem_wren),
    .busy(busy), .frame_error(frame_error)
  );

  always #5 clk = ~clk;

  typedef struct {
    int           mem;
    logic [15:0]  addr;
    logic [127:0] data;
  } wr_t;

  wr_t          obs_q[$];
  wr_t          exp_q[$];
  int           n_assert = 0;
  int           n_fail = 0;
  int           multi_cnt = 0;
  logic         exp_err = 1'b0;
  logic [15:0]  last_addr[3];
  logic [127:0] last_data[3];

  // Every write pulse seen on any memory port is logged; more than one at once is an error.
  always @(negedge clk) begin
    int n;
    n = int'(act_mem_wren) + int'(param_mem_wren) + int'(inst_mem_wren);
    if (n > 1) multi_cnt++;
    if (act_mem_wren)   obs_q.push_back('{0, 16'(act_mem_addr), 128'(act_mem_data)});
    if (param_mem_wren) obs_q.push_back('{1, 16'(param_mem_addr), param_mem_data});
    if (inst_mem_wren)  obs_q.push_back('{2, 16'(inst_mem_addr), 128'(inst_mem_data)});
  end

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_act_addr"}, 128'(act_mem_addr), 128'd0);
    chk({tag, "_act_data"}, 128'(act_mem_data), 128'd0);
    chk({tag, "_param_addr"}, 128'(param_mem_addr), 128'd0);
    chk({tag, "_param_data"}, param_mem_data, 128'd0);
    chk({tag, "_inst_addr"}, 128'(inst_mem_addr), 128'd0);
    chk({tag, "_inst_data"}, 128'(inst_mem_data), 128'd0);
    chk({tag, "_wrens"}, 128'({act_mem_wren, param_mem_wren, inst_mem_wren}), 128'd0);
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_err"}, 128'(frame_error), 128'd0);
  endtask

  // Frame-level model: header picks memory/word size; every complete group of payload bytes is
  // one write at (start + k) mod 2^addr_width, first byte in the top position.
  task automatic model_frame(input logic [7:0] f[$]);
    int mem, nb, aw, npay;
    logic [15:0] start;
    logic [127:0] w;
    if (f.size() == 0) return;
    case (f[0])
      8'h02:   begin mem = 0; nb = 1;  aw = 12; end
      8'h01:   begin mem = 1; nb = 16; aw = 13; end
      8'h03:   begin mem = 2; nb = 10; aw = 6;  end
      default: begin mem = -1; nb = 1; aw = 1;  end
    endcase
    if (mem < 0) begin
      exp_err = 1'b1;
      return;
    end
    if (f.size() < 3) begin
      exp_err = 1'b1;
      return;
    end
    start = {f[1], f[2]};
    npay  = f.size() - 3;
    for (int k = 0; k < npay / nb; k++) begin
      w = '0;
      for (int j = 0; j < nb; j++) w = {w[119:0], f[3 + k*nb + j]};
      exp_q.push_back('{mem, 16'((int'(start) + k) % (1 << aw)), w});
      last_addr[mem] = 16'((int'(start) + k) % (1 << aw));
      last_data[mem] = w;
    end
    exp_err = (npay % nb) != 0;
  endtask

  task automatic check_frame(input string tag);
    int n;
    chk({tag, "_nwrites"}, 128'(obs_q.size()), 128'(exp_q.size()));
    n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      chk($sformatf("%s_w%0d_mem", tag, i), 128'(obs_q[i].mem), 128'(exp_q[i].mem));
      chk($sformatf("%s_w%0d_addr", tag, i), 128'(obs_q[i].addr), 128'(exp_q[i].addr));
      chk($sformatf("%s_w%0d_data", tag, i), obs_q[i].data, exp_q[i].data);
    end
    obs_q.delete();
    exp_q.delete();
    chk({tag, "_err"}, 128'(frame_error), 128'(exp_err));
    chk({tag, "_busy"}, 128'(busy), 128'd0);
    chk({tag, "_multi"}, 128'(multi_cnt), 128'd0);
    chk({tag, "_act_hold"}, {act_mem_data, 16'(act_mem_addr)}, {last_data[0][7:0], last_addr[0]});
    chk({tag, "_param_hold"}, param_mem_data ^ 128'(param_mem_addr),
        last_data[1] ^ 128'(last_addr[1]));
    chk({tag, "_inst_hold"}, {inst_mem_data, 16'(inst_mem_addr)},
        {last_data[2][79:0], last_addr[2]});
  endtask

  task automatic send_byte(input logic [7:0] b, input logic fe, input int gap);
    byte_valid = 1'b1;
    byte_data  = b;
    frame_end  = fe;
    cyc();
    byte_valid = 1'b0;
    frame_end  = 1'b0;
    repeat (gap) cyc();
  endtask

  task automatic end_frame(input logic [7:0] f[$], input bit simul, input string tag);
    if (!simul) begin
      frame_end = 1'b1;
      cyc();
      frame_end = 1'b0;
    end
    cyc();
    model_frame(f);
    check_frame(tag);
  endtask

  task automatic run_frame(input logic [7:0] f[$], input bit simul, input bit rgap,
                           input string tag);
    for (int i = 0; i < f.size(); i++)
      send_byte(f[i], simul && (i == f.size() - 1), rgap ? int'($urandom_range(0, 2)) : 0);
    end_frame(f, simul, tag);
  endtask

  initial begin
    logic [7:0] f[$];
    for (int m = 0; m < 3; m++) begin
      last_addr[m] = '0;
      last_data[m] = '0;
    end
    #12;
    chk_zero("reset");
    reset_n = 1'b1;
    cyc();

    // Activation load, with busy checked right after the header byte.
    f = {8'h02, 8'h01, 8'h23, 8'hAA, 8'hBB};
    send_byte(f[0], 1'b0, 0);
    chk("act_busy", 128'(busy), 128'd1);
    for (int i = 1; i < f.size(); i++) send_byte(f[i], 1'b0, 0);
    end_frame(f, 1'b0, "act");
    chk("act_last_addr", 128'(act_mem_addr), 128'h124);

    // Parameter load of one word 0x00..0x0F.
    f = {8'h01, 8'h00, 8'h05};
    for (int i = 0; i < 16; i++) f.push_back(8'(i));
    run_frame(f, 1'b0, 1'b0, "param");
    chk("param_word", param_mem_data, 128'h000102030405060708090A0B0C0D0E0F);

    // Instruction wrap 63 -> 0.
    f = {8'h03, 8'h00, 8'h3F};
    for (int i = 0; i < 20; i++) f.push_back(8'($urandom));
    run_frame(f, 1'b0, 1'b1, "inst_wrap");
    chk("inst_wrap_addr", 128'(inst_mem_addr), 128'd0);

    // Partial parameter word, then a good activation frame clears the error.
    f = {8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 7; i++) f.push_back(8'($urandom));
    run_frame(f, 1'b0, 1'b0, "partial");
    chk("partial_err", 128'(frame_error), 128'd1);
    f = {8'h02, 8'h00, 8'h10, 8'h11, 8'h22, 8'h33};
    run_frame(f, 1'b0, 1'b0, "clear");

    // Bad header: discarded, busy and error held until frame_end.
    f = {8'h07, 8'h01, 8'h02, 8'h03, 8'h04};
    for (int i = 0; i < f.size(); i++) send_byte(f[i], 1'b0, 0);
    chk("bad_busy", 128'(busy), 128'd1);
    chk("bad_err", 128'(frame_error), 128'd1);
    end_frame(f, 1'b0, "bad");

    // Last parameter byte together with frame_end still writes.
    f = {8'h01, 8'h00, 8'h07};
    for (int i = 0; i < 16; i++) f.push_back(8'($urandom));
    run_frame(f, 1'b1, 1'b0, "simul");
    chk("simul_err", 128'(frame_error), 128'd0);

    // Random frames.
    for (int t = 0; t < 14; t++) begin
      int r;
      r = int'($urandom_range(0, 9));
      f.delete();
      f.push_back((r == 0) ? 8'h5A : 8'($urandom_range(1, 3)));
      f.push_back(8'($urandom));
      f.push_back(8'($urandom));
      repeat ($urandom_range(1, 40)) f.push_back(8'($urandom));
      run_frame(f, 1'($urandom_range(0, 1)), 1'b1, $sformatf("rnd%0d", t));
    end

    // Reset in the middle of a parameter word.
    f = {8'h01, 8'h00, 8'h00};
    for (int i = 0; i < 15; i++) f.push_back(8'($urandom));
    for (int i = 0; i < f.size(); i++) send_byte(f[i], 1'b0, 0);
    #2;
    reset_n = 1'b0;
    #1;
    chk_zero("midreset");
    for (int m = 0; m < 3; m++) begin
      last_addr[m] = '0;
      last_data[m] = '0;
    end
    exp_err = 1'b0;
    cyc();
    reset_n = 1'b1;
    cyc();
    cyc();
    chk("midreset_nowrite", 128'(obs_q.size()), 128'd0);
    f = {8'h01, 8'h00, 8'h02};
    for (int i = 0; i < 16; i++) f.push_back(8'($urandom));
    run_frame(f, 1'b0, 1'b1, "post_reset");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no end of test, expected completion");
    $fatal(1, "timeout");
  end

endmodule
